// File: rtl/hazard_pkg.sv
// Shared types and field widths for the ID/EX bubble register.
// Control bundle layout: ALUOp | Lsel | Ssel | RegDst | 8 flags.
package hazard_pkg;

    localparam int ALUOP_W  = 6;
    localparam int LSEL_W   = 3;
    localparam int SSEL_W   = 2;
    localparam int REGDST_W = 2;
    localparam int FLAG_W   = 8;
    localparam int CTRL_W   = ALUOP_W + LSEL_W + SSEL_W
                            + REGDST_W + FLAG_W;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        RESUME = 2'd2
    } state_t;

    typedef struct packed {
        logic [ALUOP_W-1:0]  aluop;
        logic [LSEL_W-1:0]   lsel;
        logic [SSEL_W-1:0]   ssel;
        logic [REGDST_W-1:0] regdst;
        logic [FLAG_W-1:0]   flags;
    } ctrl_t;

    // A hazard only opens a stall from RUN and only when bubbles are enabled.
    function automatic logic is_hazard(
        input state_t st,
        input logic   load_use,
        input logic   len_nz
    );
        return (st == RUN) && load_use && len_nz;
    endfunction

endpackage

// File: rtl/hazard_bubble_reg_if.sv
// ID/EX control bundle and hazard controls for the bubble register.
// master = ID stage / hazard unit side, slave = bubble register side.
interface hazard_bubble_reg_if #(
    parameter int CTRL_W = 21,
    parameter int BL_W   = 2,
    parameter int CNT_W  = 16
) ();

    logic [CTRL_W-1:0] CtrlIn;
    logic              InValid;
    logic              LoadUse;
    logic              Flush;
    logic              Hold;
    logic [BL_W-1:0]   BubbleLen;

    logic [CTRL_W-1:0] CtrlOut;
    logic              OutValid;
    logic              PCWrite;
    logic              IFIDWrite;
    logic              BubbleActive;
    logic [CNT_W-1:0]  BubbleCount;

    modport master (
        output CtrlIn,
        output InValid,
        output LoadUse,
        output Flush,
        output Hold,
        output BubbleLen,
        input  CtrlOut,
        input  OutValid,
        input  PCWrite,
        input  IFIDWrite,
        input  BubbleActive,
        input  BubbleCount
    );

    modport slave (
        input  CtrlIn,
        input  InValid,
        input  LoadUse,
        input  Flush,
        input  Hold,
        input  BubbleLen,
        output CtrlOut,
        output OutValid,
        output PCWrite,
        output IFIDWrite,
        output BubbleActive,
        output BubbleCount
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q <= '0;
        end else if (en && !(&q)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_bubble_reg.sv
// ID/EX control register that inserts BubbleLen bubbles per load-use hazard.
// Flush beats Hold, Hold beats the RUN/STALL/RESUME sequencing.
module hazard_bubble_reg
    import hazard_pkg::*;
#(
    parameter int CTRL_W = hazard_pkg::CTRL_W,
    parameter int BL_W   = 2,
    parameter int CNT_W  = 16
) (
    input logic Clk,
    input logic Rst,
    hazard_bubble_reg_if.slave bus
);

    state_t            state;
    logic [BL_W-1:0]   cnt;
    logic [CTRL_W-1:0] ctrl_q;
    logic              valid_q;

    logic hazard;
    logic fl_cyc;
    logic ho_cyc;
    logic go_cyc;
    logic pc_en;
    logic bub_act;
    logic cnt_en;

    assign hazard = is_hazard(state, bus.LoadUse, |bus.BubbleLen);

    // Mutually exclusive cycle classes in edge-priority order.
    assign fl_cyc = Rst && bus.Flush;
    assign ho_cyc = Rst && !bus.Flush && bus.Hold;
    assign go_cyc = Rst && !bus.Flush && !bus.Hold;

    always_comb begin
        pc_en   = 1'b0;
        bub_act = 1'b0;
        unique case (1'b1)
            fl_cyc: begin
                pc_en = 1'b1;
            end
            ho_cyc: begin
                bub_act = (state == STALL);
            end
            go_cyc: begin
                bub_act = hazard || (state == STALL);
                pc_en   = !bub_act;
            end
            default: begin
                pc_en   = 1'b0;
                bub_act = 1'b0;
            end
        endcase
    end

    assign cnt_en = go_cyc && (hazard || (state == STALL));

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (Clk),
        .clr_n (Rst),
        .en    (cnt_en),
        .q     (bus.BubbleCount)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state   <= RUN;
            cnt     <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else if (bus.Flush) begin
            state   <= RUN;
            cnt     <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else if (bus.Hold) begin
            state   <= state;
        end else begin
            unique case (state)
                RUN: begin
                    if (hazard) begin
                        ctrl_q  <= '0;
                        valid_q <= 1'b0;
                        // First bubble is this cycle; STALL covers the rest.
                        if (bus.BubbleLen == BL_W'(1)) begin
                            state <= RESUME;
                        end else begin
                            state <= STALL;
                            cnt   <= bus.BubbleLen - BL_W'(2);
                        end
                    end else begin
                        ctrl_q  <= bus.InValid ? bus.CtrlIn : '0;
                        valid_q <= bus.InValid;
                    end
                end
                STALL: begin
                    ctrl_q  <= '0;
                    valid_q <= 1'b0;
                    if (cnt == '0) begin
                        state <= RESUME;
                    end else begin
                        cnt <= cnt - BL_W'(1);
                    end
                end
                RESUME: begin
                    ctrl_q  <= bus.InValid ? bus.CtrlIn : '0;
                    valid_q <= bus.InValid;
                    state   <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign bus.CtrlOut      = ctrl_q;
    assign bus.OutValid     = valid_q;
    assign bus.PCWrite      = pc_en;
    assign bus.IFIDWrite    = pc_en;
    assign bus.BubbleActive = bub_act;

endmodule

// File: tb/tb_hazard_bubble_reg.sv
// Bench for hazard_bubble_reg: vector table with scoreboarded register outputs,
// plus a saturation sequence on a CNT_W=4 instance.
module tb_hazard_bubble_reg;

    localparam int CW = 21;
    localparam int BW = 2;
    localparam int NW = 16;
    localparam int SW = 4;

    localparam logic [CW-1:0] A = 21'h15A5A;
    localparam logic [CW-1:0] B = 21'h0F0F0;
    localparam logic [CW-1:0] C = 21'h12345;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    hazard_bubble_reg_if #(.CTRL_W(CW), .BL_W(BW), .CNT_W(NW)) bus ();
    hazard_bubble_reg_if #(.CTRL_W(CW), .BL_W(BW), .CNT_W(SW)) bus2 ();

    hazard_bubble_reg #(.CTRL_W(CW), .BL_W(BW), .CNT_W(NW)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    hazard_bubble_reg #(.CTRL_W(CW), .BL_W(BW), .CNT_W(SW)) dut_sat (
        .Clk (clk),
        .Rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic          r;
        logic [CW-1:0] ctrl;
        logic          iv;
        logic          lu;
        logic          fl;
        logic          ho;
        logic [BW-1:0] bl;
        logic          pcw;
        logic          ba;
        logic [CW-1:0] ectrl;
        logic          eov;
        logic [NW-1:0] ecnt;
    } vec_t;

    typedef struct {
        int            idx;
        logic [CW-1:0] ctrl;
        logic          ov;
        logic [NW-1:0] cnt;
    } exp_t;

    vec_t vt[$];
    exp_t sbq[$];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic add(input logic r, input logic [CW-1:0] c,
                       input logic iv, input logic lu, input logic fl,
                       input logic ho, input logic [BW-1:0] bl,
                       input logic pcw, input logic ba,
                       input logic [CW-1:0] ec, input logic eov,
                       input logic [NW-1:0] en);
        vec_t v;
        v.r = r; v.ctrl = c; v.iv = iv; v.lu = lu; v.fl = fl;
        v.ho = ho; v.bl = bl; v.pcw = pcw; v.ba = ba;
        v.ectrl = ec; v.eov = eov; v.ecnt = en;
        vt.push_back(v);
    endtask

    task automatic apply(input int i, input vec_t v);
        exp_t e;
        @(negedge clk);
        rst           = v.r;
        bus.CtrlIn    = v.ctrl;
        bus.InValid   = v.iv;
        bus.LoadUse   = v.lu;
        bus.Flush     = v.fl;
        bus.Hold      = v.ho;
        bus.BubbleLen = v.bl;
        #2;
        chk($sformatf("v%0d PCWrite", i), 32'(bus.PCWrite), 32'(v.pcw));
        chk($sformatf("v%0d IFIDWrite", i), 32'(bus.IFIDWrite), 32'(v.pcw));
        chk($sformatf("v%0d BubbleActive", i), 32'(bus.BubbleActive),
            32'(v.ba));
        e.idx = i; e.ctrl = v.ectrl; e.ov = v.eov; e.cnt = v.ecnt;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk($sformatf("v%0d scoreboard", i), 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk($sformatf("v%0d CtrlOut", e.idx), 32'(bus.CtrlOut),
                32'(e.ctrl));
            chk($sformatf("v%0d OutValid", e.idx), 32'(bus.OutValid),
                32'(e.ov));
            chk($sformatf("v%0d BubbleCount", e.idx), 32'(bus.BubbleCount),
                32'(e.cnt));
        end
    endtask

    initial begin
        bus.CtrlIn = '0; bus.InValid = 0; bus.LoadUse = 0;
        bus.Flush = 0; bus.Hold = 0; bus.BubbleLen = '0;
        bus2.CtrlIn = '0; bus2.InValid = 0; bus2.LoadUse = 0;
        bus2.Flush = 0; bus2.Hold = 0; bus2.BubbleLen = '0;

        //   r  ctrl iv lu fl ho bl pcw ba  ectrl eov ecnt
        add(0, A, 1, 0, 0, 0, 2, 0, 0, '0, 0, 0);
        add(0, B, 1, 1, 0, 0, 2, 0, 0, '0, 0, 0);
        add(1, A, 1, 0, 0, 0, 2, 1, 0, A, 1, 0);
        add(1, B, 1, 1, 0, 0, 2, 0, 1, '0, 0, 1);
        add(1, B, 1, 0, 0, 0, 2, 0, 1, '0, 0, 2);
        add(1, B, 1, 1, 0, 0, 2, 1, 0, B, 1, 2);
        add(1, C, 0, 0, 0, 0, 2, 1, 0, '0, 0, 2);
        add(1, C, 1, 1, 0, 0, 0, 1, 0, C, 1, 2);
        add(1, A, 1, 1, 0, 0, 0, 1, 0, A, 1, 2);
        add(1, B, 1, 1, 0, 0, 1, 0, 1, '0, 0, 3);
        add(1, B, 1, 0, 0, 0, 1, 1, 0, B, 1, 3);
        add(1, C, 1, 1, 0, 0, 3, 0, 1, '0, 0, 4);
        add(1, C, 1, 0, 0, 0, 0, 0, 1, '0, 0, 5);
        add(1, C, 1, 1, 1, 0, 3, 1, 0, '0, 0, 5);
        add(1, A, 1, 0, 0, 0, 3, 1, 0, A, 1, 5);
        add(1, B, 1, 1, 1, 0, 2, 1, 0, '0, 0, 5);
        add(1, B, 1, 0, 0, 0, 2, 1, 0, B, 1, 5);
        add(1, C, 1, 1, 0, 0, 3, 0, 1, '0, 0, 6);
        add(1, C, 1, 0, 0, 0, 3, 0, 1, '0, 0, 7);
        add(1, C, 1, 0, 0, 1, 3, 0, 1, '0, 0, 7);
        add(1, C, 1, 1, 0, 1, 3, 0, 1, '0, 0, 7);
        add(1, C, 1, 0, 0, 1, 3, 0, 1, '0, 0, 7);
        add(1, C, 1, 0, 0, 0, 3, 0, 1, '0, 0, 8);
        add(1, C, 1, 1, 0, 0, 3, 1, 0, C, 1, 8);
        add(1, A, 1, 0, 0, 1, 3, 0, 0, C, 1, 8);
        add(1, A, 1, 0, 0, 0, 3, 1, 0, A, 1, 8);
        add(1, B, 1, 1, 0, 0, 3, 0, 1, '0, 0, 9);
        add(0, B, 1, 0, 0, 0, 3, 0, 0, '0, 0, 0);
        add(1, B, 1, 0, 0, 0, 3, 1, 0, B, 1, 0);
        add(1, A, 1, 1, 1, 1, 3, 1, 0, '0, 0, 0);

        for (int i = 0; i < vt.size(); i++) apply(i, vt[i]);

        @(negedge clk);
        bus.InValid = 0; bus.LoadUse = 0; bus.Flush = 0; bus.Hold = 0;
        chk("sat initial", 32'(bus2.BubbleCount), 32'd0);

        for (int h = 0; h < 20; h++) begin
            @(negedge clk);
            bus2.CtrlIn = A; bus2.InValid = 1;
            bus2.LoadUse = 1; bus2.BubbleLen = 2'd1;
            #2;
            chk($sformatf("sat h%0d PCWrite", h), 32'(bus2.PCWrite), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("sat h%0d count", h), 32'(bus2.BubbleCount),
                32'((h + 1 > 15) ? 15 : h + 1));
            @(negedge clk);
            bus2.LoadUse = 0;
            @(posedge clk);
            #1;
            chk($sformatf("sat h%0d resume", h), 32'(bus2.OutValid), 32'd1);
        end

        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat hold %0d", k), 32'(bus2.BubbleCount), 32'd15);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hazard_bubble_reg.md
HAZARD_BUBBLE_REG -- requirements
Module: hazard_bubble_reg

Interface
REQ-001 Parameter CTRL_W, default 21, SHALL set the control bundle width: ALUOp 6 + Lsel 3 + Ssel 2 + RegDst 2 + 8 single-bit flags.
REQ-002 Parameter BL_W, default 2, SHALL set the BubbleLen width; BubbleLen ranges 0..2^BL_W-1.
REQ-003 Parameter CNT_W, default 16, SHALL set the bubble statistics counter width.
REQ-004 Ports (clock and reset first) SHALL be:
- Clk  in  1  sole clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-low reset.
- CtrlIn  in  CTRL_W  decoded control bundle from ID.
- InValid  in  1  CtrlIn carries a real instruction.
- LoadUse  in  1  hazard detector flags a load-use dependency.
- Flush  in  1  taken branch or jump; squash.
- Hold  in  1  external freeze, e.g. memory wait.
- BubbleLen  in  BL_W  bubbles per hazard; 0 disables insertion.
- CtrlOut  out  CTRL_W  registered ID/EX control.
- OutValid  out  1  CtrlOut holds a real instruction.
- PCWrite  out  1  PC update enable (combinational).
- IFIDWrite  out  1  IF/ID register enable (combinational).
- BubbleActive  out  1  state is STALL or a bubble is being inserted this cycle.
- BubbleCount  out  CNT_W  saturating count of inserted hazard bubbles.

Function
REQ-005 The block SHALL have states RUN, STALL and RESUME, a down-counter cnt of BL_W bits, and 1-cycle CtrlIn-to-CtrlOut latency.
REQ-006 Edge priority SHALL be: reset, then Flush, then Hold, then state logic.
REQ-007 On Flush in any state: CtrlOut<=0, OutValid<=0, state<=RUN, cnt<=0, no count; PCWrite=IFIDWrite=1 that cycle.
REQ-008 On Hold without Flush: state, cnt, CtrlOut, OutValid and BubbleCount SHALL be frozen; PCWrite=IFIDWrite=0.
REQ-009 In RUN with LoadUse and BubbleLen!=0 (a hazard): CtrlOut<=0, OutValid<=0, BubbleCount+1; PCWrite=IFIDWrite=0 that cycle; next state SHALL be RESUME if BubbleLen==1, else STALL with cnt<=BubbleLen-2.
REQ-010 In RUN without a hazard: CtrlOut<=InValid ? CtrlIn : 0 and OutValid<=InValid; an invalid slot SHALL NOT be counted; PCWrite=IFIDWrite=1.
REQ-011 In STALL: CtrlOut<=0, OutValid<=0, BubbleCount+1, PCWrite=IFIDWrite=0; if cnt==0 go to RESUME, else cnt decrements; LoadUse is ignored.
REQ-012 In RESUME: behave as RUN with no hazard (the held instruction issues), LoadUse is ignored, and next state is RUN.
REQ-013 Total bubbles per hazard SHALL equal BubbleLen exactly; BubbleLen is sampled only on hazard entry, and later changes do not affect the stall in progress.
REQ-014 BubbleCount SHALL saturate at all-ones and never wrap.
REQ-015 BubbleActive SHALL be 1 in STALL and in a RUN cycle with a hazard, and 0 otherwise, including under Flush.

Reset
REQ-016 With Rst low at an edge: CtrlOut=0, OutValid=0, BubbleCount=0, cnt=0, state=RUN.
REQ-017 While Rst is low, PCWrite=IFIDWrite=0 and BubbleActive=0.
REQ-018 Reset mid-stall SHALL abandon the stall with no residual bubbles.

Structure
REQ-019 Shared package hazard_pkg SHALL hold the state enum, the field widths (ALUOP_W=6, LSEL_W=3, SSEL_W=2, REGDST_W=2) and CTRL_W.
REQ-020 The saturating counter SHALL be the sub-module sat_counter, parametrised by CNT_W, with enable and synchronous active-low clear.

Verification
REQ-021 Reset, then CtrlIn=0x15A5A, InValid=1 -> CtrlOut=0x15A5A and OutValid=1 one edge later; PCWrite=1.
REQ-022 BubbleLen=2, LoadUse pulse, CtrlIn=A held -> exactly two zero CtrlOut cycles, PCWrite low for 2 cycles, then CtrlOut=A; BubbleCount=2.
REQ-023 BubbleLen=0 with LoadUse=1 -> no bubble, PCWrite stays 1, BubbleCount stays 0.
REQ-024 BubbleLen=3, Flush in the second STALL cycle -> CtrlOut=0, state=RUN, PCWrite=1, BubbleCount=2; LoadUse and Flush together in RUN -> Flush wins, count unchanged.
REQ-025 Hold asserted for 3 cycles mid-STALL -> CtrlOut, cnt and BubbleCount frozen; the stall completes with BubbleLen total bubbles after release.
REQ-026 CNT_W=4, 20 hazards with BubbleLen=1 -> BubbleCount=15 and holds at 15.
